// File: rtl/apb_rst_seq.sv
// apb_rst_seq: APB-programmable reset sequencer.
// Releases NUM_DOM domain resets in ascending order and re-asserts them in
// descending order. Each step waits a programmable delay. The control
// registers are clocked and reset by the APB clock and reset only, so the
// domains this block drives can never reset its own registers.
module apb_rst_seq #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_DOM    = 4,
    parameter int unsigned DLY_WIDTH  = 16,
    parameter logic [DLY_WIDTH-1:0] DLY_RESET = DLY_WIDTH'(15)
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  psel,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  penable,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  rst_req_n,
    input  logic                  wdt_rst,
    output logic [NUM_DOM-1:0]    dom_rst_n,
    output logic                  seq_busy
);

    localparam int unsigned IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

    localparam logic [7:0] ADDR_CTRL = 8'h00;
    localparam logic [7:0] ADDR_DLY  = 8'h04;
    localparam logic [7:0] ADDR_STAT = 8'h08;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_ASSERT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DLY_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_DOM-1:0]     dom_q, dom_d;

    logic                   wdt_en_q;
    logic                   soft_pend_q;
    logic                   wdt_flag_q;
    logic [DLY_WIDTH-1:0]   dly_q;

    logic                   wr_en_c;
    logic                   rd_en_c;
    logic [7:0]             addr_lo_c;
    logic                   wdt_hit_c;
    logic                   abort_c;
    logic [DATA_WIDTH-1:0]  rd_data_c;

    // Upper address bits and unmapped write-data bits are not decoded.
    logic                   apb_unused;
    assign apb_unused = ^{paddr, pwdata};

    assign wr_en_c   = psel & penable & pwrite;
    assign rd_en_c   = psel & ~penable & ~pwrite;
    assign addr_lo_c = paddr[7:0];
    assign wdt_hit_c = wdt_en_q & wdt_rst;
    assign abort_c   = ~rst_req_n | soft_pend_q | wdt_hit_c;

    assign dom_rst_n = dom_q;

    // Read data mux; unmapped addresses return zero.
    always_comb begin
        rd_data_c = '0;
        case (addr_lo_c)
            ADDR_CTRL: rd_data_c[1] = wdt_en_q;
            ADDR_DLY:  rd_data_c[DLY_WIDTH-1:0] = dly_q;
            ADDR_STAT: begin
                rd_data_c[1:0]         = 2'(state_q);
                rd_data_c[2]           = wdt_flag_q;
                rd_data_c[8 +: NUM_DOM] = dom_q;
            end
            default:   rd_data_c = '0;
        endcase
    end

    // APB-visible registers and the read data register.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            prdata      <= '0;
            wdt_en_q    <= 1'b0;
            soft_pend_q <= 1'b0;
            wdt_flag_q  <= 1'b0;
            dly_q       <= DLY_RESET;
        end else begin
            if (rd_en_c) begin
                prdata <= rd_data_c;
            end
            if (wr_en_c && addr_lo_c == ADDR_CTRL) begin
                wdt_en_q <= pwdata[1];
            end
            if (wr_en_c && addr_lo_c == ADDR_DLY) begin
                dly_q <= pwdata[DLY_WIDTH-1:0];
            end
            // A new soft-reset request outranks the clear done while holding.
            if (wr_en_c && addr_lo_c == ADDR_CTRL && pwdata[0]) begin
                soft_pend_q <= 1'b1;
            end else if (state_q == S_HOLD) begin
                soft_pend_q <= 1'b0;
            end
            // An accepted watchdog event outranks a software clear.
            if (wdt_hit_c) begin
                wdt_flag_q <= 1'b1;
            end else if (wr_en_c && addr_lo_c == ADDR_STAT && pwdata[2]) begin
                wdt_flag_q <= 1'b0;
            end
        end
    end

    // Sequencer state, step index, delay counter and domain reset register.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q  <= S_HOLD;
            idx_q    <= '0;
            cnt_q    <= '0;
            dom_q    <= '0;
            seq_busy <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dom_q    <= dom_d;
            seq_busy <= (state_d == S_RELEASE) || (state_d == S_ASSERT);
        end
    end

    // Next-state logic: ascending release, descending assert, one domain per step.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        case (state_q)
            S_HOLD: begin
                if (rst_req_n && !soft_pend_q) begin
                    state_d = S_RELEASE;
                    idx_d   = '0;
                    cnt_d   = dly_q;
                end
            end
            S_RELEASE: begin
                if (abort_c) begin
                    if (idx_q == '0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_ASSERT;
                        idx_d   = idx_q - IDX_W'(1);
                        cnt_d   = dly_q;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DLY_WIDTH'(1);
                end else begin
                    dom_d[idx_q] = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = dly_q;
                    end
                end
            end
            S_RUN: begin
                if (abort_c) begin
                    state_d = S_ASSERT;
                    idx_d   = IDX_LAST;
                    cnt_d   = dly_q;
                end
            end
            S_ASSERT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DLY_WIDTH'(1);
                end else begin
                    dom_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        state_d = S_HOLD;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                        cnt_d = dly_q;
                    end
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

endmodule

// File: tb/tb_apb_rst_seq.sv
// Directed self-checking bench for apb_rst_seq (NUM_DOM=4, DLY_RESET=15).
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, which is away from the active rising edge.
module tb_apb_rst_seq;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned ND = 4;

    logic          pclk = 1'b0;
    logic          prst;
    logic          psel;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          penable;
    logic [DW-1:0] prdata;
    logic          rst_req_n;
    logic          wdt_rst;
    logic [ND-1:0] dom_rst_n;
    logic          seq_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    apb_rst_seq #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_DOM(ND), .DLY_WIDTH(16), .DLY_RESET(16'd15)
    ) dut (
        .pclk(pclk), .prst(prst), .psel(psel), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .penable(penable), .prdata(prdata), .rst_req_n(rst_req_n),
        .wdt_rst(wdt_rst), .dom_rst_n(dom_rst_n), .seq_busy(seq_busy)
    );

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "time limit");
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = AW'(a); pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = AW'(a);
        @(negedge pclk);
        penable = 1'b1;
        d = prdata;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; rst_req_n = 1'b0; wdt_rst = 1'b0;
        repeat (2) @(negedge pclk);
        n_cmp++; if (dom_rst_n !== 4'h0) begin n_err++; $display("FAIL reset_dom: got %h want 0", dom_rst_n); end
        n_cmp++; if (seq_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", seq_busy); end
        n_cmp++; if (prdata !== 32'h0) begin n_err++; $display("FAIL reset_prdata: got %h want 0", prdata); end
        prst = 1'b0;
        @(negedge pclk);
        n_cmp++; if (dom_rst_n !== 4'h0) begin n_err++; $display("FAIL hold_dom: got %h want 0", dom_rst_n); end
        apb_read(8'h08, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL stat_after_reset: got %h want 0", rd); end
        apb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'h0000_000F) begin n_err++; $display("FAIL dly_reset: got %h want f", rd); end
        apb_write(8'h04, 32'h2);
        apb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL dly_write: got %h want 2", rd); end
    endtask

    // With DLY=2, domain k rises 3*(k+1) cycles after HOLD->RELEASE.
    task automatic test_power_up();
        logic [3:0] exp_d [13];
        logic       exp_b [13];
        logic [31:0] rd;
        exp_d = '{4'h0,4'h0,4'h0,4'h1,4'h1,4'h1,4'h3,4'h3,4'h3,4'h7,4'h7,4'h7,4'hF};
        exp_b = '{1,1,1,1,1,1,1,1,1,1,1,1,0};
        rst_req_n = 1'b1;
        for (int j = 0; j < 13; j++) begin
            @(negedge pclk);
            n_cmp++; if (dom_rst_n !== exp_d[j]) begin n_err++; $display("FAIL pu_dom[%0d]: got %h want %h", j, dom_rst_n, exp_d[j]); end
            n_cmp++; if (seq_busy !== exp_b[j]) begin n_err++; $display("FAIL pu_busy[%0d]: got %b want %b", j, seq_busy, exp_b[j]); end
        end
        apb_read(8'h08, rd);
        n_cmp++; if (rd !== 32'h0000_0F02) begin n_err++; $display("FAIL pu_stat: got %h want f02", rd); end
    endtask

    // With DLY=0, domains drop one per cycle, HOLD clears soft_pend, then release restarts.
    task automatic test_soft_reset();
        logic [3:0] exp_d [11];
        logic       exp_b [11];
        exp_d = '{4'hF,4'h7,4'h3,4'h1,4'h0,4'h0,4'h0,4'h1,4'h3,4'h7,4'hF};
        exp_b = '{1,1,1,1,0,0,1,1,1,1,0};
        apb_write(8'h04, 32'h0);
        apb_write(8'h00, 32'h1);
        for (int j = 0; j < 11; j++) begin
            @(negedge pclk);
            n_cmp++; if (dom_rst_n !== exp_d[j]) begin n_err++; $display("FAIL soft_dom[%0d]: got %h want %h", j, dom_rst_n, exp_d[j]); end
            n_cmp++; if (seq_busy !== exp_b[j]) begin n_err++; $display("FAIL soft_busy[%0d]: got %b want %b", j, seq_busy, exp_b[j]); end
        end
    endtask

    task automatic test_watchdog();
        logic [3:0] exp_d [10];
        logic [31:0] rd;
        exp_d = '{4'hF,4'h7,4'h3,4'h1,4'h0,4'h0,4'h1,4'h3,4'h7,4'hF};
        // Disabled: the pulse must be ignored.
        @(negedge pclk); wdt_rst = 1'b1;
        @(negedge pclk); wdt_rst = 1'b0;
        @(negedge pclk);
        n_cmp++; if (dom_rst_n !== 4'hF) begin n_err++; $display("FAIL wdt_off_dom: got %h want f", dom_rst_n); end
        n_cmp++; if (seq_busy !== 1'b0) begin n_err++; $display("FAIL wdt_off_busy: got %b want 0", seq_busy); end
        apb_read(8'h08, rd);
        n_cmp++; if (rd !== 32'h0000_0F02) begin n_err++; $display("FAIL wdt_off_stat: got %h want f02", rd); end
        // Enabled: descending assert, then re-release.
        apb_write(8'h00, 32'h2);
        wdt_rst = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge pclk);
            if (j == 0) wdt_rst = 1'b0;
            n_cmp++; if (dom_rst_n !== exp_d[j]) begin n_err++; $display("FAIL wdt_dom[%0d]: got %h want %h", j, dom_rst_n, exp_d[j]); end
        end
        apb_read(8'h08, rd);
        n_cmp++; if (rd !== 32'h0000_0F06) begin n_err++; $display("FAIL wdt_flag_set: got %h want f06", rd); end
        apb_read(8'h00, rd);
        n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL ctrl_read: got %h want 2", rd); end
        apb_write(8'h08, 32'h4);
        apb_read(8'h08, rd);
        n_cmp++; if (rd !== 32'h0000_0F02) begin n_err++; $display("FAIL wdt_flag_clr: got %h want f02", rd); end
        apb_write(8'h00, 32'h0);
    endtask

    // With DLY=1, rst_req_n drops at 0011, so domain 1 and then domain 0 drop.
    task automatic test_abort_release();
        logic [3:0] exp_d [10];
        bit done;
        exp_d = '{4'h0,4'h0,4'h1,4'h1,4'h3,4'h3,4'h3,4'h1,4'h1,4'h0};
        @(negedge pclk); rst_req_n = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge pclk);
            if (dom_rst_n == 4'h0 && seq_busy == 1'b0) done = 1'b1;
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL abort_drain_timeout: got dom %h want 0", dom_rst_n); end
        apb_write(8'h04, 32'h1);
        rst_req_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge pclk);
            n_cmp++; if (dom_rst_n !== exp_d[j]) begin n_err++; $display("FAIL abort_dom[%0d]: got %h want %h", j, dom_rst_n, exp_d[j]); end
            if (j == 4) rst_req_n = 1'b0;
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge pclk);
            n_cmp++; if (dom_rst_n !== 4'h0 || seq_busy !== 1'b0) begin
                n_err++; $display("FAIL abort_hold[%0d]: got dom %h busy %b want 0 0", j, dom_rst_n, seq_busy);
            end
        end
    endtask

    // The first step uses the old delay (5), and the next steps use the new delay (1).
    task automatic test_dly_change();
        logic [3:0] exp_d [13];
        logic [31:0] rd;
        exp_d = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h1,4'h1,4'h3,4'h3,4'h7,4'h7,4'hF};
        apb_write(8'h04, 32'h5);
        rst_req_n = 1'b1;
        for (int j = 0; j < 13; j++) begin
            @(negedge pclk);
            n_cmp++; if (dom_rst_n !== exp_d[j]) begin n_err++; $display("FAIL dly_dom[%0d]: got %h want %h", j, dom_rst_n, exp_d[j]); end
            if (j == 2) begin
                psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = AW'(8'h04); pwdata = 32'h1;
            end else if (j == 3) begin
                penable = 1'b1;
            end else if (j == 4) begin
                psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
            end
        end
        apb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL dly_new: got %h want 1", rd); end
    endtask

    task automatic test_readback();
        logic [31:0] rd;
        apb_read(8'h0C, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped: got %h want 0", rd); end
        apb_read(8'h08, rd);
        n_cmp++; if (rd !== 32'h0000_0F02) begin n_err++; $display("FAIL stat_run: got %h want f02", rd); end
        apb_read(8'h00, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ctrl_zero: got %h want 0", rd); end
    endtask

    // prst in the middle of ASSERT immediately clears all outputs.
    task automatic test_async_reset();
        logic [31:0] rd;
        @(negedge pclk); rst_req_n = 1'b0;
        repeat (3) @(negedge pclk);
        n_cmp++; if (dom_rst_n !== 4'h7) begin n_err++; $display("FAIL pre_prst_dom: got %h want 7", dom_rst_n); end
        #2 prst = 1'b1;
        #1;
        n_cmp++; if (dom_rst_n !== 4'h0) begin n_err++; $display("FAIL prst_dom: got %h want 0", dom_rst_n); end
        n_cmp++; if (seq_busy !== 1'b0) begin n_err++; $display("FAIL prst_busy: got %b want 0", seq_busy); end
        n_cmp++; if (prdata !== 32'h0) begin n_err++; $display("FAIL prst_prdata: got %h want 0", prdata); end
        @(negedge pclk); prst = 1'b0;
        apb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'hF) begin n_err++; $display("FAIL prst_dly: got %h want f", rd); end
        apb_read(8'h08, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL prst_stat: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_soft_reset();
        test_watchdog();
        test_abort_release();
        test_dly_change();
        test_readback();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
